// File: rtl/mac_cache_ctrl.sv
// MAC tag cache controller: arbitrates insert/lookup ports and scans newest-to-oldest.
// Optional MAC_CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module mac_cache_ctrl #(
  parameter int TAGSIZE   = 16,
  parameter int CTRSIZE   = 16,
  parameter int CACHESIZE = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  input  logic [TAGSIZE-1:0]             ins_tag,
  input  logic [CTRSIZE-1:0]             ins_ctr,
  input  logic                           lk_valid,
  output logic                           lk_ready,
  input  logic [TAGSIZE-1:0]             lk_tag,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic [CTRSIZE-1:0]             resp_ctr,
  output logic [$clog2(CACHESIZE)-1:0]   resp_idx,
  output logic [$clog2(CACHESIZE+1)-1:0] fill
`ifdef MAC_CACHE_STATS_EN
  ,
  output logic [CTRSIZE-1:0]             hit_cnt,
  output logic [CTRSIZE-1:0]             miss_cnt
`endif
);

  localparam int IW = $clog2(CACHESIZE);
  localparam int FW = $clog2(CACHESIZE + 1);

  // Handshake rule on every port: a transfer happens in a cycle where valid && ready.
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t               state, next_state;
  logic [TAGSIZE-1:0]   tag_mem [CACHESIZE];
  logic [CTRSIZE-1:0]   ctr_mem [CACHESIZE];
  logic [CACHESIZE-1:0] valid_bits;
  logic [IW-1:0]        wr_ptr;
  logic [IW-1:0]        scan_idx;
  logic [FW-1:0]        remaining;
  logic [TAGSIZE-1:0]   key;
  logic                 prio_ins;
  logic                 ins_fire, lk_fire, resp_fire, scan_hit;

  always_comb begin
    ins_ready = 1'b0;
    lk_ready  = 1'b0;
    if (!rst && state == IDLE) begin
      ins_ready = ins_valid && (!lk_valid || prio_ins);
      lk_ready  = lk_valid && (!ins_valid || !prio_ins);
    end
  end

  assign ins_fire   = ins_valid && ins_ready;
  assign lk_fire    = lk_valid && lk_ready;
  assign resp_valid = (state == RESP);
  assign resp_fire  = resp_valid && resp_ready;
  assign scan_hit   = valid_bits[scan_idx] && (tag_mem[scan_idx] == key);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (lk_fire) next_state = (fill == '0) ? RESP : SCAN;
      SCAN: if (scan_hit || remaining == FW'(1)) next_state = RESP;
      RESP: if (resp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Storage arrays carry no reset; valid_bits and fill gate every read.
  always_ff @(posedge clk) begin
    if (ins_fire) begin
      tag_mem[wr_ptr] <= ins_tag;
      ctr_mem[wr_ptr] <= ins_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      prio_ins   <= 1'b0;
      resp_hit   <= 1'b0;
      resp_ctr   <= '0;
      resp_idx   <= '0;
      scan_idx   <= '0;
      remaining  <= '0;
      key        <= '0;
    end else begin
      if (ins_fire) begin
        valid_bits[wr_ptr] <= 1'b1;
        wr_ptr             <= wr_ptr + 1'b1;
        if (fill != FW'(CACHESIZE)) fill <= fill + 1'b1;
        prio_ins <= 1'b0;
      end
      if (lk_fire) begin
        key       <= lk_tag;
        scan_idx  <= wr_ptr - 1'b1;
        remaining <= fill;
        resp_hit  <= 1'b0;
        resp_ctr  <= '0;
        resp_idx  <= '0;
        prio_ins  <= 1'b1;
      end
      // A miss leaves the zeroed result loaded at lookup acceptance.
      if (state == SCAN) begin
        if (scan_hit) begin
          resp_hit <= 1'b1;
          resp_ctr <= ctr_mem[scan_idx];
          resp_idx <= scan_idx;
        end else begin
          scan_idx  <= scan_idx - 1'b1;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

`ifdef MAC_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (resp_fire) begin
      if (resp_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/mac_cache_ctrl.md
Name: mac_cache_ctrl

Overview:
Controller and arbiter for the MAC tag cache used by the chaffing-and-winnowing datapath. It owns a CACHESIZE-entry cache of (tag, counter) pairs. Two requesters share the cache: an insert port (sender side, records newly generated MACs) and a lookup port (winnower side, checks a received tag). Lookups scan newest-to-oldest, one entry per cycle, and return hit/miss with the matching counter and index.

Parameters:
TAGSIZE, 16, width of a MAC tag
CTRSIZE, 16, width of the sequence counter stored with each tag
CACHESIZE, 64, number of cache entries (power of two, >=2)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
ins_valid  in  1  insert request
ins_ready  out  1  insert accepted this cycle
ins_tag  in  TAGSIZE  tag to insert
ins_ctr  in  CTRSIZE  counter stored with tag
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted this cycle
lk_tag  in  TAGSIZE  tag to search
resp_valid  out  1  lookup result valid
resp_ready  in  1  result consumed
resp_hit  out  1  1 = match found
resp_ctr  out  CTRSIZE  counter of matching entry (0 on miss)
resp_idx  out  $clog2(CACHESIZE)  index of matching entry (0 on miss)
fill  out  $clog2(CACHESIZE+1)  number of valid entries

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all entry valid bits=0; wr_ptr=0; fill=0; prio=LOOKUP. resp_valid=0, resp_hit=0, resp_ctr=0, resp_idx=0. ins_ready=lk_ready=0 while rst is high.
- Reset mid-operation: an in-flight scan or pending response is dropped. No response is issued for it.
- FSM states: IDLE, SCAN, RESP.
- IDLE arbitration: one grant per cycle.
  - Only ins_valid high: grant insert. Only lk_valid high: grant lookup.
  - Both high: grant the port selected by prio, then set prio to the other port.
  - A single-requester grant also sets prio to the other port.
- ins_ready and lk_ready are combinational: asserted only in IDLE, only for the granted port, and may depend on both valid inputs. Both are 0 in SCAN and RESP.
- Insert (handshake in cycle t):
  - Entry[wr_ptr] gets tag, ctr, valid=1 at the end of cycle t.
  - wr_ptr increments modulo CACHESIZE.
  - fill increments, saturating at CACHESIZE. When full, the oldest entry is overwritten.
  - The new entry is visible to any lookup accepted in cycle t+1 or later. State stays IDLE.
  - Duplicate tags are permitted.
- Lookup (handshake in cycle t):
  - lk_tag is latched. scan_idx = wr_ptr-1 (mod CACHESIZE). remaining = fill.
  - If fill==0: go to RESP with miss; resp_valid=1 from cycle t+1.
  - Otherwise go to SCAN. Each SCAN cycle compares entry[scan_idx].
    - Valid and tag equal: RESP with hit, resp_ctr/resp_idx from that entry.
    - remaining==1: RESP with miss.
    - Else: scan_idx decrements (wraps from 0 to CACHESIZE-1) and remaining decrements.
  - Latency: match at the k-th newest entry (k=1..fill) gives resp_valid from cycle t+k+1. Miss gives resp_valid from cycle t+fill+1.
  - The newest duplicate wins.
- RESP: resp_* held stable while resp_valid=1 and resp_ready=0. On resp_valid&&resp_ready: resp_valid=0 next cycle and the FSM returns to IDLE. No new grant is issued in that handshake cycle.
- Cache contents are frozen during SCAN/RESP, since no inserts are accepted then.

Optional Feature:
MAC_CACHE_STATS_EN
- Defined: adds outputs hit_cnt and miss_cnt (each CTRSIZE bits).
  - Each counts completed responses (resp_valid&&resp_ready) with resp_hit=1 or 0, respectively.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Empty lookup: after reset, lookup lk_tag=16'hBEEF -> resp_valid at t+1, resp_hit=0, resp_ctr=0, resp_idx=0; fill=0.
- Insert then hit: insert (16'h1234, ctr 5), then (16'hABCD, ctr 6); lookup 16'h1234 -> resp_valid at t+3, hit=1, ctr=5, idx=0; fill=2.
- Duplicate/newest-wins: insert (16'h0042, 1) then (16'h0042, 9); lookup 16'h0042 -> hit, ctr=9, idx=1, latency t+2.
- Wrap/overwrite: insert 65 entries tag=i, ctr=i (i=0..64) with CACHESIZE=64 -> fill=64; lookup tag 0 -> miss at t+65; lookup tag 64 -> hit, idx=0, ctr=64.
- Arbitration + backpressure + mid-op reset: hold ins_valid and lk_valid high together from reset -> grants alternate lookup, insert, lookup...; hold resp_ready=0 for 5 cycles -> resp_* stable. Assert rst during SCAN -> next cycle resp_valid=0, fill=0, state IDLE.
- (MAC_CACHE_STATS_EN) 3 hits and 2 misses consumed -> hit_cnt=3, miss_cnt=2; force 2^CTRSIZE+1 misses -> miss_cnt=16'hFFFF.
